issue_scoreboard: RTL and testbench

Decode-to-execute issue controller sitting between the instruction decoders and the execute stage. It captures one decoded instruction per cycle into a holding register, and tracks pending register writes in a 32-entry scoreboard. It issues to execute only when the instruction's source and destination registers are hazard-free, in-flight capacity is available, and serialization rules allow it. Privileged and CSR-writing instructions are serialized: they issue only into an empty pipeline and block further issue until they complete.

---
 rtl/issue_scoreboard_if.sv | 40 ++++
 rtl/issue_scoreboard.sv | 131 +++++++++++++
 tb/tb_issue_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Issue-path bundle: decoder-side capture, execute-side offer and writeback report.
// The master is the surrounding pipeline (decoder, execute, writeback); the slave is the issue scoreboard.
interface issue_scoreboard_if #(
    parameter int PAYLOAD_W = 128
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_reg1_read_en;
    logic                 in_reg2_read_en;
    logic [4:0]           in_reg1_addr;
    logic [4:0]           in_reg2_addr;
    logic                 in_reg_write_en;
    logic [4:0]           in_reg_write_addr;
    logic                 in_serial;

    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_reg_write_en;
    logic [4:0]           out_reg_write_addr;

    logic                 wb_valid;
    logic                 wb_we;
    logic [4:0]           wb_addr;

    modport master (
        output in_valid, in_payload, in_reg1_read_en, in_reg2_read_en,
               in_reg1_addr, in_reg2_addr, in_reg_write_en, in_reg_write_addr,
               in_serial, out_ready, wb_valid, wb_we, wb_addr,
        input  in_ready, out_valid, out_payload, out_reg_write_en, out_reg_write_addr
    );

    modport slave (
        input  in_valid, in_payload, in_reg1_read_en, in_reg2_read_en,
               in_reg1_addr, in_reg2_addr, in_reg_write_en, in_reg_write_addr,
               in_serial, out_ready, wb_valid, wb_we, wb_addr,
        output in_ready, out_valid, out_payload, out_reg_write_en, out_reg_write_addr
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: one-entry holding register, 32-entry pending-write scoreboard, serialization FSM.
// Latency: accept at cycle N, earliest issue at N+1; 1/cycle sustained without hazards.
// Backpressure: in_ready only when the holding slot is empty or draining this cycle; out_valid never looks at out_ready.
module issue_scoreboard #(
    parameter int PAYLOAD_W    = 128,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    issue_scoreboard_if.slave   io,
    output logic                hazard_stall,
    output logic [15:0]         stall_cnt
);
    localparam int CW = 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {RUN, DRAIN, SERIAL} state_t;

    state_t               state;
    logic                 hold_valid;
    logic [PAYLOAD_W-1:0] hold_payload;
    logic                 hold_r1_en, hold_r2_en, hold_we, hold_serial;
    logic [4:0]           hold_r1, hold_r2, hold_wa;
    logic [31:0]          sb;
    logic [CW-1:0]        cnt;

    logic [31:0]          clear_mask, set_mask, eff;
    logic [CW-1:0]        cnt_eff;
    logic                 wb_dec, hazard, issue_ok, fire, accept;

    always_comb begin
        clear_mask = '0;
        if (io.wb_valid && io.wb_we)
            clear_mask[io.wb_addr] = 1'b1;
        // A same-cycle writeback releases its register immediately.
        eff = sb & ~clear_mask;
        hazard = (hold_r1_en && eff[hold_r1]) ||
                 (hold_r2_en && eff[hold_r2]) ||
                 (hold_we    && eff[hold_wa]);

        // Writebacks with nothing in flight are ignored.
        wb_dec  = io.wb_valid && (cnt != '0);
        cnt_eff = cnt - {{(CW-1){1'b0}}, wb_dec};

        issue_ok = 1'b0;
        if (hold_valid && !hazard && state == RUN)
            issue_ok = hold_serial ? (cnt_eff == '0) : (cnt_eff < MAX_CNT);

        io.out_valid = issue_ok && !flush;
        fire         = io.out_valid && io.out_ready;
        io.in_ready  = !flush && (!hold_valid || fire);
        accept       = io.in_valid && io.in_ready;

        set_mask = '0;
        if (fire && hold_we && hold_wa != 5'd0)
            set_mask[hold_wa] = 1'b1;

        hazard_stall = hold_valid && hazard && (state == RUN);
    end

    assign io.out_payload        = hold_payload;
    assign io.out_reg_write_en   = hold_we;
    assign io.out_reg_write_addr = hold_wa;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            hold_valid   <= 1'b0;
            hold_payload <= '0;
            hold_r1_en   <= 1'b0;
            hold_r2_en   <= 1'b0;
            hold_we      <= 1'b0;
            hold_serial  <= 1'b0;
            hold_r1      <= '0;
            hold_r2      <= '0;
            hold_wa      <= '0;
            sb           <= '0;
            cnt          <= '0;
            stall_cnt    <= '0;
        end else begin
            if (hazard_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;

            if (flush) begin
                state      <= RUN;
                hold_valid <= 1'b0;
                sb         <= '0;
                cnt        <= '0;
            end else begin
                if (accept) begin
                    hold_valid   <= 1'b1;
                    hold_payload <= io.in_payload;
                    hold_r1_en   <= io.in_reg1_read_en;
                    hold_r2_en   <= io.in_reg2_read_en;
                    hold_r1      <= io.in_reg1_addr;
                    hold_r2      <= io.in_reg2_addr;
                    hold_we      <= io.in_reg_write_en;
                    hold_wa      <= io.in_reg_write_addr;
                    hold_serial  <= io.in_serial;
                end else if (fire) begin
                    hold_valid <= 1'b0;
                end

                // Set after clear so a same-register set/clear collision keeps the bit.
                sb  <= ((sb & ~clear_mask) | set_mask) & ~32'h1;
                cnt <= cnt + {{(CW-1){1'b0}}, fire} - {{(CW-1){1'b0}}, wb_dec};

                case (state)
                    RUN: begin
                        if (hold_valid && hold_serial) begin
                            if (cnt_eff != '0)
                                state <= DRAIN;
                            else if (fire)
                                state <= SERIAL;
                        end
                    end
                    DRAIN: begin
                        if (cnt_eff == '0)
                            state <= RUN;
                    end
                    SERIAL: begin
                        if (io.wb_valid)
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Random and directed issue traffic compared cycle by cycle against a queue-based reference model.
module tb_issue_scoreboard;
    localparam int PW   = 128;
    localparam int MAXI = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        hazard_stall;
    logic [15:0] stall_cnt;

    issue_scoreboard_if #(.PAYLOAD_W(PW)) io();

    issue_scoreboard #(.PAYLOAD_W(PW), .MAX_INFLIGHT(MAXI)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .io           (io),
        .hazard_stall (hazard_stall),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pl;
        bit            r1en, r2en, we, ser;
        bit [4:0]      r1, r2, wa;
    } instr_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: held instruction, pending-write set, in-flight list in completion order.
    instr_t hold_q[$];
    instr_t fired_q[$];
    bit     pend_m[32];
    int     stall_m;
    bit     drain_m, ser_wait_m;
    instr_t cur;

    bit exp_valid, exp_ready, exp_stall, fire_m;
    int eff_cnt;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit r1en, int r1, bit r2en, int r2, bit we, int wa, bit ser);
        instr_t i;
        i.pl   = {$urandom, $urandom, $urandom, $urandom};
        i.r1en = r1en; i.r1 = 5'(r1);
        i.r2en = r2en; i.r2 = 5'(r2);
        i.we   = we;   i.wa = 5'(wa);
        i.ser  = ser;
        return i;
    endfunction

    task automatic drive_in(input bit v, input instr_t i);
        cur                  = i;
        io.in_valid          = v;
        io.in_payload        = i.pl;
        io.in_reg1_read_en   = i.r1en;
        io.in_reg2_read_en   = i.r2en;
        io.in_reg1_addr      = i.r1;
        io.in_reg2_addr      = i.r2;
        io.in_reg_write_en   = i.we;
        io.in_reg_write_addr = i.wa;
        io.in_serial         = i.ser;
    endtask

    // Completions retire the oldest in-flight instruction.
    task automatic drive_wb(input bit v);
        instr_t f;
        if (v && fired_q.size() > 0) begin
            f = fired_q.pop_front();
            io.wb_valid = 1'b1;
            io.wb_we    = f.we;
            io.wb_addr  = f.wa;
        end else begin
            io.wb_valid = 1'b0;
            io.wb_we    = 1'b0;
            io.wb_addr  = 5'd0;
        end
    endtask

    task automatic model_reset();
        hold_q.delete();
        fired_q.delete();
        foreach (pend_m[r]) pend_m[r] = 1'b0;
        drain_m    = 1'b0;
        ser_wait_m = 1'b0;
    endtask

    function automatic bit busy(input bit en, input bit [4:0] r);
        bit cleared = io.wb_valid && io.wb_we && (io.wb_addr == r);
        return en && (r != 5'd0) && pend_m[r] && !cleared;
    endfunction

    task automatic eval();
        instr_t h;
        bit hold, haz, run;
        int infl = fired_q.size() + (io.wb_valid ? 1 : 0);
        hold = hold_q.size() > 0;
        if (hold) h = hold_q[0];
        haz = hold && (busy(h.r1en, h.r1) || busy(h.r2en, h.r2) || busy(h.we, h.wa));
        run = !drain_m && !ser_wait_m;
        eff_cnt   = infl - ((io.wb_valid && infl > 0) ? 1 : 0);
        exp_valid = !flush && hold && run && !haz &&
                    (h.ser ? (eff_cnt == 0) : (eff_cnt < MAXI));
        exp_stall = hold && haz && run;
        fire_m    = exp_valid && io.out_ready;
        exp_ready = !flush && (!hold || fire_m);
    endtask

    task automatic update();
        instr_t h;
        bit hold = hold_q.size() > 0;
        bit run  = !drain_m && !ser_wait_m;
        if (hold) h = hold_q[0];
        if (exp_stall && stall_m < 65535) stall_m++;
        if (flush) begin
            model_reset();
            return;
        end
        if (io.wb_valid && io.wb_we) pend_m[io.wb_addr] = 1'b0;
        if (fire_m && h.we && h.wa != 0) pend_m[h.wa] = 1'b1;
        if (ser_wait_m && io.wb_valid) ser_wait_m = 1'b0;
        if (drain_m && eff_cnt == 0) drain_m = 1'b0;
        if (run && hold && h.ser && eff_cnt != 0) drain_m = 1'b1;
        if (fire_m && h.ser) ser_wait_m = 1'b1;
        if (fire_m) begin
            fired_q.push_back(h);
            void'(hold_q.pop_front());
        end
        if (io.in_valid && exp_ready) hold_q.push_back(cur);
    endtask

    // Inputs are already driven just after a rising edge; check at the falling edge, commit at the next rising edge.
    task automatic step();
        @(negedge clk);
        eval();
        chk("out_valid", io.out_valid, exp_valid);
        chk("in_ready", io.in_ready, exp_ready);
        chk("hazard_stall", hazard_stall, exp_stall);
        chk("stall_cnt", stall_cnt, stall_m);
        if (exp_valid) begin
            chk("out_payload", io.out_payload, hold_q[0].pl);
            chk("out_we", io.out_reg_write_en, hold_q[0].we);
            chk("out_wa", io.out_reg_write_addr, hold_q[0].wa);
        end
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic go(input bit v, input instr_t i, input bit wb);
        drive_in(v, i);
        drive_wb(wb);
        step();
    endtask

    task automatic drain_all();
        io.out_ready = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (fired_q.size() == 0 && hold_q.size() == 0) break;
            go(1'b0, mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, io.out_valid, 1'b0);
        chk({tag, "_in_ready"}, io.in_ready, 1'b1);
        chk({tag, "_hazard_stall"}, hazard_stall, 1'b0);
        chk({tag, "_stall_cnt"}, stall_cnt, 16'd0);
        chk({tag, "_out_payload"}, io.out_payload, '0);
        chk({tag, "_out_we"}, io.out_reg_write_en, 1'b0);
        chk({tag, "_out_wa"}, io.out_reg_write_addr, 5'd0);
    endtask

    initial begin
        instr_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        drive_in(1'b0, nop);
        io.out_ready = 1'b1;
        drive_wb(1'b0);
        model_reset();
        stall_m = 0;

        #3;
        check_reset_outputs("reset");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Independent stream writing r1, r2, r3.
        go(1, mk(1, 0, 0, 0, 1, 1, 0), 0);
        go(1, mk(1, 0, 0, 0, 1, 2, 0), 0);
        go(1, mk(0, 0, 1, 0, 1, 3, 0), 0);
        go(0, nop, 0);
        chk("stream_inflight_busy_r3", io.in_ready, 1'b1);
        drain_all();

        // RAW on r5, released by a same-cycle writeback.
        go(1, mk(0, 0, 0, 0, 1, 5, 0), 0);
        go(1, mk(1, 5, 0, 0, 1, 6, 0), 0);
        go(0, nop, 0);
        go(0, nop, 0);
        go(0, nop, 1);
        drain_all();

        // Capacity: five independent writers, no completions, then one completion.
        for (int k = 1; k <= 5; k++) go(1, mk(0, 0, 0, 0, 1, 8 + k, 0), 0);
        go(0, nop, 0);
        go(0, nop, 0);
        go(0, nop, 1);
        drain_all();

        // Serialization: two in flight, CSR write drains then issues alone.
        go(1, mk(0, 0, 0, 0, 1, 1, 0), 0);
        go(1, mk(0, 0, 0, 0, 1, 2, 0), 0);
        go(1, mk(0, 0, 0, 0, 1, 7, 1), 0);
        go(1, mk(0, 0, 0, 0, 1, 20, 0), 0);
        go(1, mk(0, 0, 0, 0, 1, 21, 0), 1);
        go(1, mk(0, 0, 0, 0, 1, 21, 0), 1);
        go(1, mk(0, 0, 0, 0, 1, 21, 0), 0);
        go(0, nop, 0);
        go(0, nop, 1);
        drain_all();

        // Flush with three in flight and a held hazard.
        go(1, mk(0, 0, 0, 0, 1, 1, 0), 0);
        go(1, mk(0, 0, 0, 0, 1, 2, 0), 0);
        go(1, mk(0, 0, 0, 0, 1, 3, 0), 0);
        go(1, mk(1, 1, 0, 0, 1, 4, 0), 0);
        go(0, nop, 0);
        flush = 1'b1;
        go(1, mk(0, 0, 0, 0, 1, 9, 0), 1);
        flush = 1'b0;
        go(1, mk(1, 1, 1, 2, 1, 3, 0), 0);
        go(0, nop, 0);
        drain_all();

        // Asynchronous reset while a serial instruction is outstanding.
        go(1, mk(0, 0, 0, 0, 1, 7, 1), 0);
        go(1, mk(0, 0, 0, 0, 1, 8, 0), 0);
        go(0, nop, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        stall_m = 0;
        drive_wb(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        go(0, nop, 0);

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            instr_t r;
            r = mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 15) == 0);
            io.out_ready = $urandom_range(0, 4) != 0;
            flush = $urandom_range(0, 63) == 0;
            drive_in($urandom_range(0, 3) != 0, r);
            if (fired_q.size() == 0 && $urandom_range(0, 19) == 0) begin
                io.wb_valid = 1'b1;
                io.wb_we    = 1'(($urandom_range(0, 1)));
                io.wb_addr  = 5'($urandom_range(0, 31));
            end else begin
                drive_wb($urandom_range(0, 2) == 0);
            end
            step();
        end
        flush = 1'b0;
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
